uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/uart_rx_fifo.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: receiver FSM states and parity mode encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word, registered flags and occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]    count_n;
  logic [WIDTH-1:0] head_n;
  logic             push_ok, pop_ok;

  // Full is checked before the pop, so a push into a full FIFO drops even if a pop completes.
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    rd_ptr_n = rd_ptr + AW'(pop_ok);
    count_n  = count + CW'(push_ok) - CW'(pop_ok);
    head_n   = (push_ok && (wr_ptr == rd_ptr_n)) ? din : mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Head word is precomputed so dout is a plain register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      dout   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      full   <= (count_n == CW'(DEPTH));
      empty  <= (count_n == '0);
      if (count_n != '0) dout <= head_n;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable data/parity/stop) feeding a receive FIFO with error pulses.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow
);

  localparam int unsigned TW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned BW   = 4;

  rx_state_e              state, state_n;
  logic [TW-1:0]          timer, timer_n;
  logic [BW-1:0]          bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic                   stop_cnt, stop_cnt_n;
  logic                   stop_bad, stop_bad_n;
  logic                   par_bad, par_bad_n;
  logic                   rx_meta, rxs, rxs_d;
  logic                   tick_c, bad_c, push_c, ferr_c, perr_c;
  logic                   fifo_full, fifo_empty;

  // Two-flop synchronizer plus one delay flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      stop_cnt   <= 1'b0;
      stop_bad   <= 1'b0;
      par_bad    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      stop_cnt   <= stop_cnt_n;
      stop_bad   <= stop_bad_n;
      par_bad    <= par_bad_n;
      frame_err  <= ferr_c;
      parity_err <= perr_c;
      overflow   <= push_c & fifo_full;
    end
  end

  always_comb begin
    state_n    = state;
    tick_c     = (timer == TW'(CLKS_PER_BIT - 1));
    timer_n    = tick_c ? '0 : timer + TW'(1);
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    stop_cnt_n = stop_cnt;
    stop_bad_n = stop_bad;
    par_bad_n  = par_bad;
    bad_c      = stop_bad | ~rxs;
    push_c     = 1'b0;
    ferr_c     = 1'b0;
    perr_c     = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (rxs_d && !rxs) state_n = START;
      end
      START: begin
        if (timer == TW'(HALF - 1)) begin
          timer_n   = '0;
          bit_cnt_n = '0;
          state_n   = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_c) begin
          shreg_n   = {rxs, shreg[DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + BW'(1);
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            stop_cnt_n = 1'b0;
            stop_bad_n = 1'b0;
            par_bad_n  = 1'b0;
            state_n    = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick_c) begin
          par_bad_n = rxs ^ (^shreg) ^ (PARITY_MODE == PARITY_ODD);
          state_n   = STOP;
        end
      end
      STOP: begin
        if (tick_c) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            if (bad_c) begin
              ferr_c  = 1'b1;
              state_n = WAIT_IDLE;
            end else if (par_bad) begin
              perr_c  = 1'b1;
              state_n = IDLE;
            end else begin
              push_c  = 1'b1;
              state_n = IDLE;
            end
          end else begin
            stop_cnt_n = 1'b1;
            stop_bad_n = bad_c;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must return high before a new start is accepted.
        timer_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .din   (shreg),
    .pop   (m_ready),
    .dout  (m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_valid = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance at 16 clocks per bit.
module tb_uart_rx_fifo;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx, rx_p;
  logic       m_ready, m_ready_p;
  logic [7:0] m_data, m_data_p;
  logic       m_valid, m_valid_p;
  logic [4:0] fifo_count, fifo_count_p;
  logic       frame_err, parity_err, overflow;
  logic       frame_err_p, parity_err_p, overflow_p;

  int errors = 0;
  int checks = 0;
  int ferr_cnt = 0, perr_cnt = 0, ovf_cnt = 0, excl_cnt = 0;
  int ferr_cnt_p = 0, perr_cnt_p = 0, ovf_cnt_p = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY_MODE (0), .STOP_BITS (1), .FIFO_DEPTH (16)
  ) dut (
    .clk (clk), .rst_n (rst_n), .rx (rx), .m_data (m_data), .m_valid (m_valid),
    .m_ready (m_ready), .fifo_count (fifo_count), .frame_err (frame_err),
    .parity_err (parity_err), .overflow (overflow)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY_MODE (1), .STOP_BITS (1), .FIFO_DEPTH (16)
  ) dut_p (
    .clk (clk), .rst_n (rst_n), .rx (rx_p), .m_data (m_data_p), .m_valid (m_valid_p),
    .m_ready (m_ready_p), .fifo_count (fifo_count_p), .frame_err (frame_err_p),
    .parity_err (parity_err_p), .overflow (overflow_p)
  );

  // Count flag-high cycles; any cycle with two flags high is an exclusivity violation.
  always @(negedge clk) begin
    if (frame_err)    ferr_cnt++;
    if (parity_err)   perr_cnt++;
    if (overflow)     ovf_cnt++;
    if (frame_err_p)  ferr_cnt_p++;
    if (parity_err_p) perr_cnt_p++;
    if (overflow_p)   ovf_cnt_p++;
    if (int'(frame_err) + int'(parity_err) + int'(overflow) > 1) excl_cnt++;
    if (int'(frame_err_p) + int'(parity_err_p) + int'(overflow_p) > 1) excl_cnt++;
  end

  task automatic send_bit(input bit sel, input logic b);
    if (sel) rx_p = b; else rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                            input logic pbit, input logic stop_v);
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
    if (use_par) send_bit(sel, pbit);
    send_bit(sel, stop_v);
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({m_valid, fifo_count, m_data, frame_err, parity_err, overflow} !== 17'h0) begin
      errors++;
      $display("FAIL reset_8n1: valid=%b count=%0d data=%h flags=%b%b%b, want all 0",
               m_valid, fifo_count, m_data, frame_err, parity_err, overflow);
    end
    checks++;
    if ({m_valid_p, fifo_count_p, m_data_p, frame_err_p, parity_err_p, overflow_p} !== 17'h0) begin
      errors++;
      $display("FAIL reset_8e1: valid=%b count=%0d data=%h, want all 0",
               m_valid_p, fifo_count_p, m_data_p);
    end
  endtask

  // 'T' frame with exact push latency: m_valid rises one cycle after the stop mid-sample.
  task automatic test_single();
    logic [7:0] d;
    d = 8'h54;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b0, d[i]);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: m_valid=%b at stop mid-sample, want 0", m_valid);
    end
    @(negedge clk);
    checks++;
    if ({m_valid, m_data, fifo_count} !== {1'b1, 8'h54, 5'd1}) begin
      errors++;
      $display("FAIL single_push: valid=%b data=%h count=%0d, want 1 54 1",
               m_valid, m_data, fifo_count);
    end
    repeat (5) @(negedge clk);
    pop_one();
    checks++;
    if ({m_valid, fifo_count} !== {1'b0, 5'd0}) begin
      errors++;
      $display("FAIL single_pop: valid=%b count=%0d, want 0 0", m_valid, fifo_count);
    end
  endtask

  task automatic test_burst_overflow();
    string s;
    s = "The start of cod";
    for (int i = 0; i < 16; i++) send_frame(1'b0, 8'(s[i]), 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if ({fifo_count, ovf_cnt} !== {5'd16, 32'd0}) begin
      errors++;
      $display("FAIL burst_fill: count=%0d ovf=%0d, want 16 0", fifo_count, ovf_cnt);
    end
    send_frame(1'b0, 8'h65, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if ({fifo_count, ovf_cnt, ferr_cnt, perr_cnt} !== {5'd16, 32'd1, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL overflow: count=%0d ovf=%0d ferr=%0d perr=%0d, want 16 1 0 0",
               fifo_count, ovf_cnt, ferr_cnt, perr_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({m_valid, m_data} !== {1'b1, 8'(s[i])}) begin
        errors++;
        $display("FAIL burst_order[%0d]: valid=%b data=%h, want 1 %h",
                 i, m_valid, m_data, 8'(s[i]));
      end
      pop_one();
    end
    checks++;
    if ({m_valid, fifo_count} !== {1'b0, 5'd0}) begin
      errors++;
      $display("FAIL burst_drain: valid=%b count=%0d, want 0 0", m_valid, fifo_count);
    end
  endtask

  task automatic test_glitch();
    int f0, p0;
    f0 = ferr_cnt; p0 = perr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if ({m_valid, fifo_count} !== {1'b0, 5'd0} || ferr_cnt != f0 || perr_cnt != p0) begin
      errors++;
      $display("FAIL glitch: valid=%b count=%0d ferr=%0d perr=%0d, want no push no flags",
               m_valid, fifo_count, ferr_cnt - f0, perr_cnt - p0);
    end
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({m_valid, m_data} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL glitch_recover: valid=%b data=%h, want 1 a5", m_valid, m_data);
    end
    pop_one();
  endtask

  // 0x54 has three ones, so the even parity bit is 1.
  task automatic test_parity();
    send_frame(1'b1, 8'h54, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if ({perr_cnt_p, ferr_cnt_p, fifo_count_p} !== {32'd1, 32'd0, 5'd0}) begin
      errors++;
      $display("FAIL parity_bad: perr=%0d ferr=%0d count=%0d, want 1 0 0",
               perr_cnt_p, ferr_cnt_p, fifo_count_p);
    end
    send_frame(1'b1, 8'h54, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if ({perr_cnt_p, fifo_count_p, m_data_p} !== {32'd1, 5'd1, 8'h54}) begin
      errors++;
      $display("FAIL parity_good: perr=%0d count=%0d data=%h, want 1 1 54",
               perr_cnt_p, fifo_count_p, m_data_p);
    end
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = ferr_cnt;
    send_frame(1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    checks++;
    if (ferr_cnt - f0 != 1 || fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL frame_err: pulses=%0d count=%0d, want 1 0", ferr_cnt - f0, fifo_count);
    end
    rx = 1'b1;
    repeat (32) @(negedge clk);
    send_frame(1'b0, 8'h2E, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if ({ferr_cnt - f0, fifo_count, m_data} !== {32'd1, 5'd1, 8'h2E}) begin
      errors++;
      $display("FAIL frame_recover: pulses=%0d count=%0d data=%h, want 1 1 2e",
               ferr_cnt - f0, fifo_count, m_data);
    end
  endtask

  // FIFO still holds 0x2E here, so the reset clear is observable.
  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'h68;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, d[i]);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    checks++;
    if ({m_valid, fifo_count, m_data, frame_err, parity_err, overflow} !== 17'h0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b count=%0d data=%h flags=%b%b%b, want all 0",
               m_valid, fifo_count, m_data, frame_err, parity_err, overflow);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(1'b0, 8'h68, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if ({m_valid, fifo_count, m_data} !== {1'b1, 5'd1, 8'h68}) begin
      errors++;
      $display("FAIL reset_recover: valid=%b count=%0d data=%h, want 1 1 68",
               m_valid, fifo_count, m_data);
    end
  endtask

  initial begin
    rst_n = 1'b0; rx = 1'b1; rx_p = 1'b1; m_ready = 1'b0; m_ready_p = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    test_single();
    test_burst_overflow();
    test_glitch();
    test_parity();
    test_frame_err();
    test_reset_mid_frame();
    checks++;
    if (excl_cnt != 0) begin
      errors++;
      $display("FAIL flag_exclusive: overlap cycles=%0d, want 0", excl_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
